// File: rtl/vector_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : vector_loader_if
// Description : Element-stream, operand-write and status bundle between the
//               vector loader (master) and its environment (slave). The
//               ref_dot member exists only when LOADER_REFDOT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface vector_loader_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 12,
    parameter int VALUE_WIDTH   = 4
);
    logic                     start;
    logic                     elem_valid;
    logic                     elem_ready;
    logic [VALUE_WIDTH-1:0]   elem_a;
    logic [VALUE_WIDTH-1:0]   elem_b;
    logic                     fsm_ready;
    logic                     WR;
    logic [ADDRESS_WIDTH-1:0] wraddr;
    logic [DATA_WIDTH-1:0]    dataIn1;
    logic [DATA_WIDTH-1:0]    dataIn2;
    logic                     startProcessing_rd;
    logic                     load_done;
    logic                     busy;
`ifdef LOADER_REFDOT_EN
    logic [2*DATA_WIDTH:0]    ref_dot;
`endif

    modport master (
        input  start, elem_valid, elem_a, elem_b, fsm_ready,
        output elem_ready, WR, wraddr, dataIn1, dataIn2,
               startProcessing_rd, load_done, busy
`ifdef LOADER_REFDOT_EN
        , output ref_dot
`endif
    );

    modport slave (
        output start, elem_valid, elem_a, elem_b, fsm_ready,
        input  elem_ready, WR, wraddr, dataIn1, dataIn2,
               startProcessing_rd, load_done, busy
`ifdef LOADER_REFDOT_EN
        , input ref_dot
`endif
    );
endinterface
`default_nettype wire

// File: rtl/vector_loader.sv
`default_nettype none
// ============================================================================
// Module      : vector_loader
// Description : Packs a serial (a, b) element stream into VECTOR_LENGTH-lane
//               operand words and writes 2**ADDRESS_WIDTH of them into the
//               dot-product operand memory, then flags processing start.
//               Define LOADER_REFDOT_EN to add the ref_dot reference output.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_loader #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 12,
    parameter int VALUE_WIDTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    vector_loader_if.master  bus
);

    localparam int VECTOR_LENGTH = DATA_WIDTH / VALUE_WIDTH;
    localparam int LANE_W        = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
    localparam logic [LANE_W-1:0]        LAST_LANE = LANE_W'(VECTOR_LENGTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_WRITE    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [ADDRESS_WIDTH-1:0] wraddr_q, wraddr_d;
    logic [DATA_WIDTH-1:0]    data1_q, data1_d;
    logic [DATA_WIDTH-1:0]    data2_q, data2_d;

    logic wr_o;
    logic elem_ready_o;
    logic busy_o;
    logic done_o;
    logic accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lane_q   <= '0;
            wraddr_q <= '0;
            data1_q  <= '0;
            data2_q  <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            wraddr_q <= wraddr_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        wraddr_d     = wraddr_q;
        data1_d      = data1_q;
        data2_d      = data2_q;
        wr_o         = 1'b0;
        elem_ready_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        accept       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_COLLECT;
                    wraddr_d = '0;
                    lane_d   = '0;
                    data1_d  = '0;
                    data2_d  = '0;
                end
            end

            S_COLLECT: begin
                elem_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (bus.elem_valid) begin
                    accept = 1'b1;
                    // Only the addressed lane changes; upper lanes keep stale data.
                    for (int l = 0; l < VECTOR_LENGTH; l++) begin
                        if (lane_q == LANE_W'(l)) begin
                            data1_d[l*VALUE_WIDTH +: VALUE_WIDTH] = bus.elem_a;
                            data2_d[l*VALUE_WIDTH +: VALUE_WIDTH] = bus.elem_b;
                        end
                    end
                    if (lane_q == LAST_LANE) begin
                        state_d = S_WAIT_RDY;
                        lane_d  = '0;
                    end else begin
                        lane_d  = lane_q + LANE_W'(1);
                    end
                end
            end

            S_WAIT_RDY: begin
                busy_o = 1'b1;
                if (bus.fsm_ready) begin
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                busy_o = 1'b1;
                wr_o   = 1'b1;
                if (wraddr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_COLLECT;
                    wraddr_d = wraddr_q + ADDRESS_WIDTH'(1);
                end
            end

            S_DONE: begin
                done_o = 1'b1;
                if (bus.start) begin
                    state_d  = S_COLLECT;
                    wraddr_d = '0;
                    lane_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.elem_ready         = elem_ready_o;
    assign bus.WR                 = wr_o;
    assign bus.wraddr             = wraddr_q;
    assign bus.dataIn1            = data1_q;
    assign bus.dataIn2            = data2_q;
    assign bus.startProcessing_rd = done_o;
    assign bus.load_done          = done_o;
    assign bus.busy               = busy_o;

`ifdef LOADER_REFDOT_EN
    localparam int DOT_W = 2*DATA_WIDTH + 1;

    logic [2*VALUE_WIDTH-1:0] prod;
    logic [DOT_W-1:0]         dot_q, dot_d;

    assign prod = (2*VALUE_WIDTH)'(bus.elem_a) * (2*VALUE_WIDTH)'(bus.elem_b);

    // The first accepted lane restarts the sum for the new vector.
    always_comb begin
        dot_d = dot_q;
        if (accept) begin
            dot_d = ((lane_q == '0) ? '0 : dot_q) + DOT_W'(prod);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dot_q <= '0;
        end else begin
            dot_q <= dot_d;
        end
    end

    assign bus.ref_dot = dot_q;
`endif

endmodule
`default_nettype wire

// File: doc/vector_loader.md
Name: vector_loader

Overview:
Upstream feeder for the dot-product FIFO/FSM top. It accepts a serial stream of element pairs (a, b) over a valid/ready handshake and packs VECTOR_LENGTH pairs into one dataIn1/dataIn2 word pair. It writes each packed pair into the top's operand memory with WR/wraddr, gated by fsm_ready. After all 2**ADDRESS_WIDTH addresses are written, it raises startProcessing_rd.

Parameters:
ADDRESS_WIDTH, 5, operand memory address width; N = 2**ADDRESS_WIDTH vectors per load
DATA_WIDTH, 12, packed vector width; must be a multiple of VALUE_WIDTH
VALUE_WIDTH, 4, element width; localparam VECTOR_LENGTH = DATA_WIDTH/VALUE_WIDTH

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a load of N vectors
elem_valid  in  1  element pair valid
elem_ready  out  1  loader can accept an element pair
elem_a  in  VALUE_WIDTH  element for dataIn1
elem_b  in  VALUE_WIDTH  element for dataIn2
fsm_ready  in  1  top can accept a write
WR  out  1  write strobe to top, one cycle per vector
wraddr  out  ADDRESS_WIDTH  write address
dataIn1  out  DATA_WIDTH  packed vector 1
dataIn2  out  DATA_WIDTH  packed vector 2
startProcessing_rd  out  1  level; high once all N vectors are written
load_done  out  1  level; same timing as startProcessing_rd
busy  out  1  high in every state except IDLE and DONE

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, lane counter 0, address 0.
- States: IDLE, COLLECT, WAIT_RDY, WRITE, DONE.
- IDLE: start=1 -> COLLECT, wraddr<=0, lane<=0, dataIn1/dataIn2<=0.
- COLLECT: elem_ready=1. On elem_valid&elem_ready, elem_a goes to dataIn1[lane*VALUE_WIDTH +: VALUE_WIDTH] and elem_b to the same slice of dataIn2. Lane 0 is at the LSBs. lane increments. Accepting lane VECTOR_LENGTH-1 -> WAIT_RDY, lane<=0.
- WAIT_RDY: elem_ready=0. fsm_ready sampled 1 -> WRITE. Waits indefinitely otherwise.
- WRITE: WR=1 for exactly this cycle. wraddr, dataIn1 and dataIn2 are stable during the strobe. Next state:
  - wraddr==N-1 -> DONE.
  - otherwise -> COLLECT, with wraddr incremented on exit.
- dataIn1/dataIn2 hold their last value after the write, until the first accept of the next vector overwrites lane 0. Upper lanes keep stale data until they are overwritten.
- DONE: startProcessing_rd=1, load_done=1, elem_ready=0. start=1 -> COLLECT, clearing both flags and setting wraddr<=0.
- start in COLLECT, WAIT_RDY or WRITE: ignored.
- elem_valid outside COLLECT: ignored; no element is consumed.
- Minimum cost per vector: VECTOR_LENGTH accept cycles + 1 WAIT_RDY cycle + 1 WRITE cycle = 5 cycles at defaults.
- wraddr does not wrap during a load; the address after N-1 is never issued.
- rst asserted mid-load: immediate return to IDLE, all outputs 0. Partially collected data is discarded and no WR is issued.
- fsm_ready dropping in WRITE does not cancel the already-issued WR.

Optional Feature:
LOADER_REFDOT_EN
- Defined:
  - Adds output ref_dot [2*DATA_WIDTH:0]: the unsigned sum of elem_a*elem_b over the vector's lanes, accumulated as elements are accepted.
  - ref_dot is valid in the WRITE cycle (when WR=1) and held until the next vector's first accept, which clears it.
  - Reset value 0.
  - Used as a bench scoreboard source.
- Undefined: the port and the accumulator are absent; all other behaviour is unchanged.

Test Plan:
- Reset check: rst=1, then apply elem_valid=1 and start=1 for 3 cycles -> every output stays 0 (elem_ready=0, busy=0).
- Single vector packing: pulse start, feed pairs (0,2),(1,3),(2,4) with fsm_ready=1 -> WR pulses once with wraddr=0, dataIn1=12'h210, dataIn2=12'h432. With LOADER_REFDOT_EN, ref_dot=11.
- Full load: feed 3*N pairs, a=val and b=val+2, val incrementing mod 16 -> 32 WR pulses at wraddr 0..31. startProcessing_rd and load_done rise the cycle after the WR at wraddr=31, and busy drops.
- Backpressure: hold fsm_ready=0 for 20 cycles after vector 0 is collected -> no WR, elem_ready=0 throughout. WR asserts exactly 1 cycle after fsm_ready returns to 1.
- Stalled stream: toggle elem_valid 1/0 each cycle -> packing is identical to the single-vector case and no element is duplicated or skipped.
- Reset mid-load: assert rst after 2 elements of vector 5 -> outputs return to 0. A new start reloads from wraddr=0.
